vga_draw_engine: RTL

//  Command-driven pixel writer between the CPU bus latch and the VGA framebuffer write port.
//  The CPU loads X/Y/COLOR/LEN registers, then writes CMD to queue PLOT, HLINE, VLINE or CLEAR.

---
 rtl/vga_draw_engine_if.sv | 27 ++
 rtl/vga_draw_engine.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/vga_draw_engine_if.sv
// Bus between the CPU register latch / framebuffer write port and the draw engine.
// fb_we is the valid and fb_ready the ready: a pixel moves on a cycle with both high;
// while fb_we is high and fb_ready low, fb_x/fb_y/fb_color are held stable.
interface vga_draw_engine_if;
   logic       wr_en;
   logic [2:0] wr_addr;
   logic [7:0] wr_data;
   logic       busy;
   logic       full;
   logic       ovf;
   logic [7:0] fb_x;
   logic [6:0] fb_y;
   logic [2:0] fb_color;
   logic       fb_we;
   logic       fb_ready;
   logic [1:0] dbg_state;

   modport master (
      output wr_en, wr_addr, wr_data, fb_ready,
      input  busy, full, ovf, fb_x, fb_y, fb_color, fb_we, dbg_state
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, fb_ready,
      output busy, full, ovf, fb_x, fb_y, fb_color, fb_we, dbg_state
   );
endinterface

// File: rtl/vga_draw_engine.sv
// Command-driven pixel writer: shadow registers, a small command FIFO and an
// IDLE/LOAD/DRAW engine that expands PLOT/HLINE/VLINE/CLEAR into framebuffer writes.
module vga_draw_engine #(
   parameter int FB_W       = 160,
   parameter int FB_H       = 120,
   parameter int FIFO_DEPTH = 4
) (
   input  logic             CLK,
   input  logic             RES,
   vga_draw_engine_if.slave bus
);

   localparam int         PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [PW:0] DEPTH_C = (PW + 1)'(FIFO_DEPTH);
   localparam logic [8:0] W_LIM   = 9'(FB_W);
   localparam logic [8:0] H_LIM   = 9'(FB_H);
   localparam logic [8:0] W_MAX   = 9'(FB_W - 1);
   localparam logic [8:0] H_MAX   = 9'(FB_H - 1);

   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_LOAD = 2'd1, ST_DRAW = 2'd2} state_t;
   typedef enum logic [1:0] {OP_PLOT = 2'd0, OP_HLINE = 2'd1, OP_VLINE = 2'd2, OP_CLEAR = 2'd3} op_t;

   typedef struct packed {
      op_t        op;
      logic [7:0] x;
      logic [7:0] y;
      logic [7:0] len;
      logic [2:0] color;
   } cmd_t;

   state_t        state;
   logic [7:0]    x_r, y_r, len_r;
   logic [2:0]    color_r;
   logic          ovf_r;
   cmd_t          fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr;
   logic [PW:0]   count;
   cmd_t          ent, new_cmd;
   logic [8:0]    cur_x, cur_y, end_x, end_y;
   logic          fb_we_r;
   logic          push, push_ok, pop, full, on_screen, xfer, last_px;
   logic [8:0]    h_end, v_end;

   always_comb begin
      full      = (count == DEPTH_C);
      push      = bus.wr_en && (bus.wr_addr == 3'd4);
      push_ok   = push && !full;
      pop       = (state == ST_IDLE) && (count != '0);
      new_cmd   = '{op: op_t'(bus.wr_data[1:0]), x: x_r, y: y_r, len: len_r, color: color_r};
      on_screen = ({1'b0, ent.x} < W_LIM) && ({1'b0, ent.y} < H_LIM);
      // 9-bit sums so a start near the edge plus LEN=255 clips instead of wrapping
      h_end = {1'b0, ent.x} + {1'b0, ent.len};
      if (h_end > W_MAX) h_end = W_MAX;
      v_end = {1'b0, ent.y} + {1'b0, ent.len};
      if (v_end > H_MAX) v_end = H_MAX;
      xfer    = fb_we_r && bus.fb_ready;
      last_px = (cur_x == end_x) && (cur_y == end_y);
   end

   always_ff @(posedge CLK) begin
      if (RES) begin
         x_r     <= '0;
         y_r     <= '0;
         len_r   <= '0;
         color_r <= '0;
         ovf_r   <= 1'b0;
      end else begin
         if (bus.wr_en) begin
            case (bus.wr_addr)
               3'd0:    x_r     <= bus.wr_data;
               3'd1:    y_r     <= bus.wr_data;
               3'd2:    color_r <= bus.wr_data[2:0];
               3'd3:    len_r   <= bus.wr_data;
               3'd5:    ovf_r   <= 1'b0;
               default: ;
            endcase
         end
         if (push && full) ovf_r <= 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (push_ok) fifo_mem[wr_ptr] <= new_cmd;
   end

   always_ff @(posedge CLK) begin
      if (RES) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RES) begin
         state   <= ST_IDLE;
         ent     <= '0;
         cur_x   <= '0;
         cur_y   <= '0;
         end_x   <= '0;
         end_y   <= '0;
         fb_we_r <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pop) begin
                  ent   <= fifo_mem[rd_ptr];
                  state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (ent.op == OP_CLEAR) begin
                  cur_x   <= '0;
                  cur_y   <= '0;
                  end_x   <= W_MAX;
                  end_y   <= H_MAX;
                  fb_we_r <= 1'b1;
                  state   <= ST_DRAW;
               end else if (on_screen) begin
                  cur_x   <= {1'b0, ent.x};
                  cur_y   <= {1'b0, ent.y};
                  end_x   <= (ent.op == OP_HLINE) ? h_end : {1'b0, ent.x};
                  end_y   <= (ent.op == OP_VLINE) ? v_end : {1'b0, ent.y};
                  fb_we_r <= 1'b1;
                  state   <= ST_DRAW;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_DRAW: begin
               if (xfer) begin
                  if (last_px) begin
                     fb_we_r <= 1'b0;
                     state   <= ST_IDLE;
                  end else begin
                     case (ent.op)
                        OP_HLINE: cur_x <= cur_x + 1'b1;
                        OP_VLINE: cur_y <= cur_y + 1'b1;
                        OP_CLEAR: begin
                           if (cur_x == W_MAX) begin
                              cur_x <= '0;
                              cur_y <= cur_y + 1'b1;
                           end else begin
                              cur_x <= cur_x + 1'b1;
                           end
                        end
                        default: ;
                     endcase
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy      = (count != '0) || (state != ST_IDLE);
   assign bus.full      = full;
   assign bus.ovf       = ovf_r;
   assign bus.fb_x      = cur_x[7:0];
   assign bus.fb_y      = cur_y[6:0];
   assign bus.fb_color  = ent.color;
   assign bus.fb_we     = fb_we_r;
   assign bus.dbg_state = state;

endmodule
